// File: rtl/placer_pkg.sv
// Shared types for the shelf placement engine: FSM states, placement modes,
// the shelf record and the strike sentinel.
package placer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic MODE_FIRST = 1'b0;
  localparam logic MODE_BEST  = 1'b1;

  // Shelf fields are stored wide enough for any practical board and narrowed by users.
  localparam int unsigned COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t base_y;
    coord_t sh;
    coord_t fx;
  } shelf_t;

  function automatic coord_t strike_sentinel(input int unsigned idx_w);
    return coord_t'((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/placer_shelf_table.sv
// Shelf register file: one combinational read port for the scan, one fill
// update or shelf append per cycle, and a synchronous clear.
module placer_shelf_table
  import placer_pkg::*;
#(
  parameter int unsigned N_SHELF = 8,
  parameter int unsigned AW      = (N_SHELF > 1) ? $clog2(N_SHELF) : 1,
  parameter int unsigned UW      = $clog2(N_SHELF + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [AW-1:0] rd_idx_i,
  output shelf_t        rd_shelf_o,
  input  logic          upd_en_i,
  input  logic [AW-1:0] upd_idx_i,
  input  coord_t        upd_fx_i,
  input  logic          app_en_i,
  input  coord_t        app_sh_i,
  input  coord_t        app_fx_i,
  output logic [UW-1:0] used_o,
  output coord_t        next_y_o
);

  shelf_t        shelves_q [N_SHELF];
  shelf_t        shelves_d [N_SHELF];
  logic [UW-1:0] used_q, used_d;
  coord_t        next_y_q, next_y_d;

  always_comb begin
    shelves_d = shelves_q;
    used_d    = used_q;
    next_y_d  = next_y_q;
    if (clr_i) begin
      used_d   = '0;
      next_y_d = '0;
    end else if (upd_en_i) begin
      shelves_d[upd_idx_i].fx = upd_fx_i;
    end else if (app_en_i) begin
      shelves_d[AW'(used_q)] = '{base_y: next_y_q, sh: app_sh_i, fx: app_fx_i};
      used_d   = used_q + UW'(1);
      next_y_d = next_y_q + app_sh_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shelves_q <= '{default: '0};
      used_q    <= '0;
      next_y_q  <= '0;
    end else begin
      shelves_q <= shelves_d;
      used_q    <= used_d;
      next_y_q  <= next_y_d;
    end
  end

  assign rd_shelf_o = shelves_q[rd_idx_i];
  assign used_o     = used_q;
  assign next_y_o   = next_y_q;

endmodule

// File: rtl/placer_shelf_engine.sv
// Shelf-packing placement engine: scans every shelf once per request, then
// places on a fitting shelf, opens a new one, or strikes.
//
// state  | meaning
// IDLE   | ready for a request
// SCAN   | one shelf per cycle, tracking the first/best candidate
// DECIDE | pick result, update the shelf table and strike count
// RESP   | hold result until the consumer takes it
module placer_shelf_engine
  import placer_pkg::*;
#(
  parameter int unsigned BOARD_W  = 128,
  parameter int unsigned BOARD_H  = 128,
  parameter int unsigned N_SHELF  = 8,
  parameter int unsigned DIM_W    = 5,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned STRIKE_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DIM_W-1:0]    height_i,
  input  logic [DIM_W-1:0]    width_i,
  input  logic                mode_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [IDX_W-1:0]    index_x_o,
  output logic [IDX_W-1:0]    index_y_o,
  output logic                strike_flag_o,
  output logic [STRIKE_W-1:0] strike_o
);

  localparam int unsigned EW = IDX_W + 1;
  localparam int unsigned AW = (N_SHELF > 1) ? $clog2(N_SHELF) : 1;
  localparam int unsigned UW = $clog2(N_SHELF + 1);
  localparam logic [AW-1:0]    K_LAST     = AW'(N_SHELF - 1);
  localparam logic [EW-1:0]    BW_E       = EW'(BOARD_W);
  localparam logic [EW-1:0]    BH_E       = EW'(BOARD_H);
  localparam logic [IDX_W-1:0] IDX_STRIKE = IDX_W'(strike_sentinel(IDX_W));

  state_e               state_q, state_d;
  logic [AW-1:0]        k_q, k_d;
  logic [DIM_W-1:0]     h_q, h_d, w_q, w_d;
  logic                 mode_q, mode_d;
  logic                 found_q, found_d;
  logic [AW-1:0]        best_k_q, best_k_d;
  logic [EW-1:0]        best_slack_q, best_slack_d;
  logic [EW-1:0]        best_x_q, best_x_d, best_y_q, best_y_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     idx_x_q, idx_x_d, idx_y_q, idx_y_d;
  logic                 strike_flag_q, strike_flag_d;
  logic [STRIKE_W-1:0]  strike_q, strike_d;

  shelf_t        rd_shelf;
  logic [UW-1:0] used;
  coord_t        next_y;
  logic          upd_en, app_en;
  coord_t        upd_fx, app_sh, app_fx;

  logic [EW-1:0] sh_e, fx_e, by_e, h_e, w_e, ny_e, slack;
  logic          fit, take, zero_dim, can_open;

  placer_shelf_table #(
    .N_SHELF (N_SHELF),
    .AW      (AW),
    .UW      (UW)
  ) u_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .rd_idx_i   (k_q),
    .rd_shelf_o (rd_shelf),
    .upd_en_i   (upd_en),
    .upd_idx_i  (best_k_q),
    .upd_fx_i   (upd_fx),
    .app_en_i   (app_en),
    .app_sh_i   (app_sh),
    .app_fx_i   (app_fx),
    .used_o     (used),
    .next_y_o   (next_y)
  );

  always_comb begin
    sh_e     = EW'(rd_shelf.sh);
    fx_e     = EW'(rd_shelf.fx);
    by_e     = EW'(rd_shelf.base_y);
    h_e      = EW'(h_q);
    w_e      = EW'(w_q);
    ny_e     = EW'(next_y);
    slack    = sh_e - h_e;
    fit      = (UW'(k_q) < used) && (sh_e >= h_e) && ((fx_e + w_e) <= BW_E);
    // Strict '<' keeps the lowest shelf on best-fit ties.
    take     = fit && (!found_q || ((mode_q == MODE_BEST) && (slack < best_slack_q)));
    zero_dim = (h_q == '0) || (w_q == '0);
    can_open = (used < UW'(N_SHELF)) && ((ny_e + h_e) <= BH_E) && (w_e <= BW_E);
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    h_d           = h_q;
    w_d           = w_q;
    mode_d        = mode_q;
    found_d       = found_q;
    best_k_d      = best_k_q;
    best_slack_d  = best_slack_q;
    best_x_d      = best_x_q;
    best_y_d      = best_y_q;
    out_valid_d   = out_valid_q;
    idx_x_d       = idx_x_q;
    idx_y_d       = idx_y_q;
    strike_flag_d = strike_flag_q;
    strike_d      = strike_q;
    upd_en        = 1'b0;
    app_en        = 1'b0;
    upd_fx        = coord_t'(best_x_q + w_e);
    app_sh        = coord_t'(h_e);
    app_fx        = coord_t'(w_e);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          h_d     = height_i;
          w_d     = width_i;
          mode_d  = mode_i;
          k_d     = '0;
          found_d = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (take) begin
          found_d      = 1'b1;
          best_k_d     = k_q;
          best_slack_d = slack;
          best_x_d     = fx_e;
          best_y_d     = by_e;
        end
        if (k_q == K_LAST) state_d = ST_DECIDE;
        else               k_d     = k_q + AW'(1);
      end
      ST_DECIDE: begin
        out_valid_d = 1'b1;
        state_d     = ST_RESP;
        if (zero_dim || (!found_q && !can_open)) begin
          idx_x_d       = IDX_STRIKE;
          idx_y_d       = IDX_STRIKE;
          strike_flag_d = 1'b1;
          if (strike_q != '1) strike_d = strike_q + STRIKE_W'(1);
        end else if (found_q) begin
          idx_x_d       = IDX_W'(best_x_q);
          idx_y_d       = IDX_W'(best_y_q);
          strike_flag_d = 1'b0;
          upd_en        = !clr_i;
        end else begin
          idx_x_d       = '0;
          idx_y_d       = IDX_W'(ny_e);
          strike_flag_d = 1'b0;
          app_en        = !clr_i;
        end
      end
      ST_RESP: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr_i) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      strike_d    = '0;
      found_d     = 1'b0;
    end
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      h_q           <= '0;
      w_q           <= '0;
      mode_q        <= MODE_FIRST;
      found_q       <= 1'b0;
      best_k_q      <= '0;
      best_slack_q  <= '0;
      best_x_q      <= '0;
      best_y_q      <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      idx_x_q       <= '0;
      idx_y_q       <= '0;
      strike_flag_q <= 1'b0;
      strike_q      <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      h_q           <= h_d;
      w_q           <= w_d;
      mode_q        <= mode_d;
      found_q       <= found_d;
      best_k_q      <= best_k_d;
      best_slack_q  <= best_slack_d;
      best_x_q      <= best_x_d;
      best_y_q      <= best_y_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      idx_x_q       <= idx_x_d;
      idx_y_q       <= idx_y_d;
      strike_flag_q <= strike_flag_d;
      strike_q      <= strike_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign index_x_o     = idx_x_q;
  assign index_y_o     = idx_y_q;
  assign strike_flag_o = strike_flag_q;
  assign strike_o      = strike_q;

endmodule

// File: tb/tb_placer_shelf_engine.sv
// Directed bench for placer_shelf_engine with hand-computed placements.
module tb_placer_shelf_engine;

  localparam int N_SHELF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] height = '0;
  logic [4:0] width = '0;
  logic       mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] idx_x, idx_y;
  logic       strike_flag;
  logic [3:0] strike;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  placer_shelf_engine #(
    .BOARD_W  (128),
    .BOARD_H  (128),
    .N_SHELF  (N_SHELF),
    .DIM_W    (5),
    .IDX_W    (8),
    .STRIKE_W (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clr_i         (clr),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .height_i      (height),
    .width_i       (width),
    .mode_i        (mode),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .index_x_o     (idx_x),
    .index_y_o     (idx_y),
    .strike_flag_o (strike_flag),
    .strike_o      (strike)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Issue one request and check latency and the full result, then handshake.
  task automatic req(input string tag, input int h, input int w, input logic m,
                     input int ex, input int ey, input logic ef, input int es);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".rdy"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    height   = 5'(h);
    width    = 5'(w);
    mode     = m;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, N_SHELF + 1);
    chk({tag, ".x"}, 32'(idx_x), ex);
    chk({tag, ".y"}, 32'(idx_y), ey);
    chk({tag, ".flag"}, 32'(strike_flag), 32'(ef));
    chk({tag, ".strike"}, 32'(strike), es);
    if (out_ready) tick();
  endtask

  initial begin
    int n;
    logic seen;

    repeat (10) @(posedge clk);
    #1;
    chk("rst.ready", 32'(in_ready), 1);
    chk("rst.valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("rst.x", 32'(idx_x), 0);
    chk("rst.y", 32'(idx_y), 0);
    chk("rst.flag", 32'(strike_flag), 0);
    chk("rst.strike", 32'(strike), 0);
    chk("rst.ready2", 32'(in_ready), 1);

    // First-fit sequence
    req("ff0", 4, 10, 1'b0, 0, 0, 1'b0, 0);
    req("ff1", 3, 20, 1'b0, 10, 0, 1'b0, 0);
    req("ff2", 6, 5, 1'b0, 0, 4, 1'b0, 0);
    chk("ff.hold.x", 32'(idx_x), 0);
    chk("ff.hold.y", 32'(idx_y), 4);
    chk("ff.hold.valid", 32'(out_valid), 0);

    // Best-fit: shelf0 sh=8 fill 120, shelf1 sh=4 at y=8 fill 10
    do_clr();
    req("bs0", 8, 30, 1'b0, 0, 0, 1'b0, 0);
    req("bs1", 8, 30, 1'b0, 30, 0, 1'b0, 0);
    req("bs2", 8, 30, 1'b0, 60, 0, 1'b0, 0);
    req("bs3", 8, 30, 1'b0, 90, 0, 1'b0, 0);
    req("bs4", 4, 10, 1'b0, 0, 8, 1'b0, 0);
    req("best", 3, 5, 1'b1, 10, 8, 1'b0, 0);
    req("first", 3, 5, 1'b0, 120, 0, 1'b0, 0);

    // Height overflow: four shelves of 31, four 31-wide programs each
    do_clr();
    for (int i = 0; i < 16; i++)
      req($sformatf("ho%0d", i), 31, 31, 1'b0, (i % 4) * 31, (i / 4) * 31, 1'b0, 0);
    req("ho.strike", 31, 31, 1'b0, 255, 255, 1'b1, 1);
    for (int i = 0; i < 16; i++)
      req($sformatf("sat%0d", i), 31, 31, 1'b0, 255, 255, 1'b1, (i + 2 > 15) ? 15 : i + 2);
    req("zero_h", 0, 7, 1'b0, 255, 255, 1'b1, 15);
    req("zero_w", 1, 0, 1'b0, 255, 255, 1'b1, 15);
    req("after0", 1, 4, 1'b0, 124, 0, 1'b0, 15);

    // Width wrap
    do_clr();
    for (int i = 0; i < 5; i++)
      req($sformatf("ww%0d", i), 4, 25, 1'b0, i * 25, 0, 1'b0, 0);
    req("ww5", 4, 25, 1'b0, 0, 4, 1'b0, 0);

    // Backpressure: (5,3) opens a shelf at y=8
    out_ready = 1'b0;
    req("bp", 5, 3, 1'b0, 0, 8, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.valid", i), 32'(out_valid), 1);
      chk($sformatf("bp%0d.ready", i), 32'(in_ready), 0);
      chk($sformatf("bp%0d.y", i), 32'(idx_y), 8);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp.drop", 32'(out_valid), 0);
    chk("bp.keep_y", 32'(idx_y), 8);
    chk("bp.ready", 32'(in_ready), 1);

    // Clear mid-scan
    req("pre_clr", 0, 7, 1'b0, 255, 255, 1'b1, 1);
    in_valid = 1'b1;
    height   = 5'd4;
    width    = 5'd10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("clr.busy", 32'(in_ready), 0);
    do_clr();
    chk("clr.strike", 32'(strike), 0);
    chk("clr.ready", 32'(in_ready), 1);
    seen = 1'b0;
    n = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen = 1'b1;
      n++;
    end
    chk("clr.noout", 32'(seen), 0);
    req("clr.next", 4, 10, 1'b0, 0, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
